// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns, digit codes and scan FSM encoding
package seg_pkg;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] BLANK   = 4'hF;
    localparam logic [3:0] INVALID = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_t;

    // Exactly one anode driven low selects a digit
    function automatic logic an_single(input logic [3:0] a);
        return (a == 4'hE) || (a == 4'hD) || (a == 4'hB) || (a == 4'h7);
    endfunction

    // Two or more anodes low at once is never a valid scan state
    function automatic logic an_illegal(input logic [3:0] a);
        return !an_single(a) && (a != 4'hF);
    endfunction

    // Slot number of the low anode bit; only meaningful when an_single()
    function automatic logic [1:0] an_index(input logic [3:0] a);
        case (a)
            4'hE:    return 2'd0;
            4'hD:    return 2'd1;
            4'hB:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low seven-segment pattern to digit code lookup
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code
);

    // Anything that is not a known digit or fully dark decodes as INVALID
    always_comb begin
        code = INVALID;
        case (seg)
            SEG_0:   code = 4'd0;
            SEG_1:   code = 4'd1;
            SEG_2:   code = 4'd2;
            SEG_3:   code = 4'd3;
            SEG_4:   code = 4'd4;
            SEG_5:   code = 4'd5;
            SEG_6:   code = 4'd6;
            SEG_7:   code = 4'd7;
            SEG_8:   code = 4'd8;
            SEG_9:   code = 4'd9;
            SEG_OFF: code = BLANK;
            default: code = INVALID;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - recovers four digits from a multiplexed 7-seg scan (SEG_SYNC_EN adds input synchronizers)
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    input  logic       dp,
    output logic [3:0] mt,
    output logic [3:0] mo,
    output logic [3:0] st,
    output logic [3:0] so,
    output logic [3:0] dp_cap,
    output logic       frame_valid,
    output logic       err_seg,
    output logic       err_an,
    output logic       stale
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int SW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STALE_MAX   = SW'(FRAME_TIMEOUT);

    logic [3:0] an_s;
    logic [6:0] seg_s;
    logic       dp_s;

`ifdef SEG_SYNC_EN
    logic [11:0] sync1, sync2;

    // Two-flop synchronizer; resets to the idle bus (gap, dark, dp off)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= {4'hF, SEG_OFF, 1'b1};
            sync2 <= {4'hF, SEG_OFF, 1'b1};
        end else begin
            sync1 <= {an, seg, dp};
            sync2 <= sync1;
        end
    end

    assign {an_s, seg_s, dp_s} = sync2;
`else
    assign {an_s, seg_s, dp_s} = {an, seg, dp};
`endif

    scan_state_t     state, state_next;
    logic [CW-1:0]   cnt;
    logic            cnt_clr, cnt_inc, capture;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            dp_q;
    logic            illegal_q;
    logic            changed, an_changed, single_now, illegal_now;
    logic [3:0]      dec_code;
    logic [1:0]      slot_sel;
    logic [3:0]      seen, seen_next;
    logic            frame_done;
    logic [3:0][3:0] shadow, slot_new;
    logic [3:0]      shadow_dp, dp_new;
    logic [SW-1:0]   stale_cnt;

    assign single_now  = an_single(an_s);
    assign illegal_now = an_illegal(an_s);
    assign an_changed  = (an_s != an_q);
    assign changed     = an_changed || (seg_s != seg_q) || (dp_s != dp_q);
    assign slot_sel    = an_index(an_s);
    assign seen_next   = seen | (4'b0001 << slot_sel);
    assign frame_done  = capture && (seen_next == 4'hF);

    seg7_decode u_decode (
        .seg  (seg_s),
        .code (dec_code)
    );

    // Previous-cycle copy of the bus for change detection and err_an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q      <= 4'hF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            an_q      <= an_s;
            seg_q     <= seg_s;
            dp_q      <= dp_s;
            illegal_q <= illegal_now;
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_WAIT;
        else     state <= state_next;
    end

    // Next state: settle on a single anode, capture once, hold until anode moves
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_WAIT: begin
                if (single_now) begin
                    state_next = ST_SETTLE;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!single_now) begin
                    state_next = ST_WAIT;
                end else if (changed) begin
                    cnt_clr = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_HELD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_HELD: begin
                if (an_changed) state_next = ST_WAIT;
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // Settle counter: stable cycles seen on the current anode
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) cnt <= '0;
        else if (cnt_inc)   cnt <= cnt + 1'b1;
    end

    // Shadow contents as they will be after this cycle's capture
    always_comb begin
        slot_new = shadow;
        dp_new   = shadow_dp;
        if (capture) begin
            slot_new[slot_sel] = dec_code;
            dp_new[slot_sel]   = ~dp_s;
        end
    end

    // Shadow slots and seen bits; a completed frame restarts the seen set
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
            seen      <= '0;
        end else if (capture) begin
            shadow    <= slot_new;
            shadow_dp <= dp_new;
            seen      <= frame_done ? 4'h0 : seen_next;
        end
    end

    // Published digits and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mt          <= '0;
            mo          <= '0;
            st          <= '0;
            so          <= '0;
            dp_cap      <= '0;
            frame_valid <= 1'b0;
            err_seg     <= 1'b0;
            err_an      <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            err_seg     <= capture && (dec_code == INVALID);
            err_an      <= illegal_now && !illegal_q;
            if (frame_done) begin
                mt     <= slot_new[3];
                mo     <= slot_new[2];
                st     <= slot_new[1];
                so     <= slot_new[0];
                dp_cap <= dp_new;
            end
        end
    end

    // Stale watchdog: saturating cycle count since the last frame; a frame clears it
    always_ff @(posedge clk) begin
        if (rst || frame_done) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (stale_cnt != STALE_MAX) begin
            stale_cnt <= stale_cnt + 1'b1;
            if (stale_cnt == STALE_MAX - 1'b1) stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - directed self-checking bench for seg_scan_capture
module tb_seg_scan_capture;

    localparam int SC = 4;
    localparam int FT = 1000;
`ifdef SEG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [6:0] P0 = 7'h40, P1 = 7'h79, P2 = 7'h24, P3 = 7'h30, P4 = 7'h19;
    localparam logic [6:0] P5 = 7'h12, P6 = 7'h02, P7 = 7'h78, P8 = 7'h00, P9 = 7'h10;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [3:0] mt, mo, st, so, dp_cap;
    logic       frame_valid, err_seg, err_an, stale;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fv_cnt = 0, es_cnt = 0, ea_cnt = 0;
    int t_fv = 0, t_set = 0;
    logic stale_at_fv = 1'b0;

    always #5 clk = ~clk;

    seg_scan_capture #(.SETTLE_CYCLES(SC), .FRAME_TIMEOUT(FT)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .mt          (mt),
        .mo          (mo),
        .st          (st),
        .so          (so),
        .dp_cap      (dp_cap),
        .frame_valid (frame_valid),
        .err_seg     (err_seg),
        .err_an      (err_an),
        .stale       (stale)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt      <= fv_cnt + 1;
            t_fv        <= cyc;
            stale_at_fv <= stale;
        end
        if (err_seg) es_cnt <= es_cnt + 1;
        if (err_an)  ea_cnt <= ea_cnt + 1;
    end

    typedef struct {
        logic [6:0] p3, p2, p1, p0;
        logic [3:0] dpn;
        logic [15:0] exp_digits;
        logic [3:0] exp_dp;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_digit(input logic [3:0] a, input logic [6:0] s, input logic d);
        @(negedge clk);
        an = a; seg = s; dp = d; t_set = cyc;
        repeat (100) @(negedge clk);
        an = 4'hF; seg = 7'h7F; dp = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_scan(input logic [6:0] p3, p2, p1, p0, input logic [3:0] dpn);
        drive_digit(4'h7, p3, dpn[3]);
        drive_digit(4'hB, p2, dpn[2]);
        drive_digit(4'hD, p1, dpn[1]);
        drive_digit(4'hE, p0, dpn[0]);
    endtask

    function automatic logic [23:0] all_outs();
        return {mt, mo, st, so, dp_cap, frame_valid, err_seg, err_an, stale};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0, es0, ea0;

        vecs[0] = '{P1, P2, P3, P4, 4'hF, 16'h1234, 4'h0, 0};
        vecs[1] = '{P5, P6, P7, P8, 4'hB, 16'h5678, 4'h4, 0};
        vecs[2] = '{P9, P0, 7'h7F, 7'h7F, 4'hF, 16'h90FF, 4'h0, 0};
        vecs[3] = '{P0, P8, 7'h7E, 7'h7F, 4'hF, 16'h08EF, 4'h0, 1};
        vecs[4] = '{P3, P9, P0, P6, 4'h0, 16'h3906, 4'hF, 0};
        vecs[5] = '{7'h7F, 7'h41, P1, P7, 4'h6, 16'hFE17, 4'h9, 1};

        rst = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(all_outs()), 64'h0);
        rst = 1'b0;

        // stale asserts on exactly the FT-th cycle with the bus idle
        repeat (FT - 1) @(negedge clk);
        chk("stale_before_timeout", 64'(stale), 64'h0);
        @(negedge clk);
        chk("stale_at_timeout", 64'(stale), 64'h1);

        for (int i = 0; i < 6; i++) begin
            fv0 = fv_cnt; es0 = es_cnt;
            drive_scan(vecs[i].p3, vecs[i].p2, vecs[i].p1, vecs[i].p0, vecs[i].dpn);
            chk($sformatf("v%0d_frames", i), 64'(fv_cnt - fv0), 64'd1);
            chk($sformatf("v%0d_digits", i), 64'({mt, mo, st, so}), 64'(vecs[i].exp_digits));
            chk($sformatf("v%0d_dp_cap", i), 64'(dp_cap), 64'(vecs[i].exp_dp));
            chk($sformatf("v%0d_err_seg", i), 64'(es_cnt - es0), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_latency", i), 64'(t_fv - t_set), 64'(SC + 1 + LAT));
            chk($sformatf("v%0d_stale_at_fv", i), 64'(stale_at_fv), 64'h0);
        end

        // seg change while held is ignored: first stable value wins
        @(negedge clk);
        an = 4'h7; seg = P1; dp = 1'b1;
        repeat (20) @(negedge clk);
        seg = P7;
        repeat (80) @(negedge clk);
        an = 4'hF; seg = 7'h7F;
        repeat (3) @(negedge clk);
        drive_digit(4'hB, P2, 1'b1);
        drive_digit(4'hD, P3, 1'b1);
        drive_digit(4'hE, P4, 1'b1);
        chk("held_ignore_digits", 64'({mt, mo, st, so}), 64'h1234);

        // seg toggling every 3 cycles never settles
        fv0 = fv_cnt; es0 = es_cnt;
        @(negedge clk);
        an = 4'h7;
        for (int k = 0; k < 20; k++) begin
            seg = (k % 2 == 0) ? P3 : P2;
            repeat (3) @(negedge clk);
        end
        an = 4'hF; seg = 7'h7F;
        repeat (3) @(negedge clk);
        drive_digit(4'hB, P5, 1'b1);
        drive_digit(4'hD, P6, 1'b1);
        drive_digit(4'hE, P7, 1'b1);
        chk("toggle_no_frame", 64'(fv_cnt - fv0), 64'd0);
        drive_digit(4'h7, P9, 1'b1);
        chk("toggle_then_frame", 64'(fv_cnt - fv0), 64'd1);
        chk("toggle_digits", 64'({mt, mo, st, so}), 64'h9567);
        chk("toggle_err_seg", 64'(es_cnt - es0), 64'd0);

        // illegal anode: single err_an pulse, partial frame kept
        drive_digit(4'h7, P8, 1'b1);
        drive_digit(4'hB, P0, 1'b1);
        fv0 = fv_cnt; ea0 = ea_cnt;
        @(negedge clk);
        an = 4'h3; seg = P1;
        repeat (50) @(negedge clk);
        an = 4'hF; seg = 7'h7F;
        repeat (3) @(negedge clk);
        chk("illegal_err_an", 64'(ea_cnt - ea0), 64'd1);
        chk("illegal_no_frame", 64'(fv_cnt - fv0), 64'd0);
        drive_digit(4'hD, P5, 1'b1);
        drive_digit(4'hE, P2, 1'b1);
        chk("illegal_frames", 64'(fv_cnt - fv0), 64'd1);
        chk("illegal_digits", 64'({mt, mo, st, so}), 64'h8052);

        // reset mid-scan discards the partial frame
        drive_digit(4'h7, P3, 1'b1);
        drive_digit(4'hB, P4, 1'b1);
        drive_digit(4'hD, P5, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midscan_reset_outputs", 64'(all_outs()), 64'h0);
        rst = 1'b0;
        fv0 = fv_cnt;
        drive_digit(4'hE, P6, 1'b1);
        chk("after_reset_partial", 64'(fv_cnt - fv0), 64'd0);
        drive_digit(4'h7, P7, 1'b1);
        drive_digit(4'hB, P8, 1'b1);
        drive_digit(4'hD, P9, 1'b1);
        chk("after_reset_frames", 64'(fv_cnt - fv0), 64'd1);
        chk("after_reset_digits", 64'({mt, mo, st, so}), 64'h7896);
        chk("after_reset_latency", 64'(t_fv - t_set), 64'(SC + 1 + LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
